// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous fifo block.
// It issues rd_en to the FIFO, absorbs the one-cycle registered read latency,
// and presents words on a valid/ready stream through a 2-entry buffer.
// This gives one word per cycle when downstream is ready, and backpressure
// never overruns the buffer.
// Optional feature: define FIFO_READER_CNT_EN to build the delivered-word
// counter on word_count. When it is undefined, word_count is tied to zero.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy
);

    // Buffer occupancy states
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic                  inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q;     // head entry
    logic [DATA_WIDTH-1:0] buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q;     // second entry
    logic [DATA_WIDTH-1:0] buf1_d;

    logic                  valid_s;
    logic                  pop_s;
    logic [2:0]            committed_s; // words buffered or in flight after this cycle's pop
    logic                  rd_en_s;

    // The head word is visible whenever anything is buffered.
    assign valid_s = (occ_q != OCC_EMPTY);
    assign pop_s   = valid_s && m_ready;

    // Count buffered and in-flight words, net of this cycle's pop.
    // A pop implies at least one buffered word, so the subtraction cannot underflow.
    assign committed_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};

    // A read is issued only if its word is guaranteed a slot in the buffer.
    // It is never issued against an empty FIFO, and never while reset is held.
    assign rd_en_s = rst && en && !fifo_empty && (committed_s < 3'd2);

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_s;
    assign m_data     = buf0_q;
    assign busy       = valid_s || inflight_q;

    // An issued read makes its data arrive, and be captured, on the next cycle.
    always_comb begin
        inflight_d = rd_en_s;
    end

    // Buffer next state: capture the in-flight word at the tail and shift on pop.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (inflight_q) begin
                    buf0_d = fifo_dout;
                    occ_d  = OCC_ONE;
                end else begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_ONE: begin
                if (inflight_q && pop_s) begin
                    buf0_d = fifo_dout;
                    occ_d  = OCC_ONE;
                end else if (inflight_q) begin
                    buf1_d = fifo_dout;
                    occ_d  = OCC_FULL;
                end else if (pop_s) begin
                    occ_d  = OCC_EMPTY;
                end else begin
                    occ_d  = OCC_ONE;
                end
            end
            OCC_FULL: begin
                // Capture without pop cannot happen here: the read gate
                // refuses a read that would need a third slot.
                if (pop_s) begin
                    buf0_d = buf1_q;
                    if (inflight_q) begin
                        buf1_d = fifo_dout;
                        occ_d  = OCC_FULL;
                    end else begin
                        occ_d  = OCC_ONE;
                    end
                end else begin
                    occ_d = OCC_FULL;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // State registers. Reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            buf0_q     <= {DATA_WIDTH{1'b0}};
            buf1_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_READER_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Delivered-word counter. It advances on every pop and wraps naturally.
    always_comb begin
        if (pop_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_count = cnt_q;
`else
    assign word_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
